// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : bip_control_unit
// Description : Control unit for the BIP1 core. Owns the program counter,
//               addresses program memory, decodes the fetched instruction
//               and drives the datapath / data-memory control strobes.
//               Executes one instruction per clock from RUN until HLT.
// Ports       : i_clk, i_rst (async, active-high), i_start,
//               i_instruction (program word at o_pc, same cycle),
//               o_pc, o_operand, o_SelA, o_SelB, o_WrAcc, o_op,
//               o_WrRam, o_RdRam, o_halt, o_illegal, o_count
// Revision    : 1.0 - initial release
// ============================================================================
module bip_control_unit #(
  parameter int NB_INSTR  = 16,
  parameter int NB_OPCODE = 5,
  parameter int NB_ADDR   = 11,
  parameter int NB_COUNT  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_INSTR-1:0] i_instruction,
  output logic [NB_ADDR-1:0]  o_pc,
  output logic [NB_ADDR-1:0]  o_operand,
  output logic [1:0]          o_SelA,
  output logic                o_SelB,
  output logic                o_WrAcc,
  output logic                o_op,
  output logic                o_WrRam,
  output logic                o_RdRam,
  output logic                o_halt,
  output logic                o_illegal,
  output logic [NB_COUNT-1:0] o_count
);

  // FSM encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;

  // Opcodes
  localparam logic [NB_OPCODE-1:0] c_op_hlt  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] c_op_sto  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] c_op_ld   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] c_op_ldi  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] c_op_add  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] c_op_addi = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] c_op_sub  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] c_op_subi = NB_OPCODE'(7);

  // SelA source encodings
  localparam logic [1:0] c_sela_mem = 2'b00;
  localparam logic [1:0] c_sela_imm = 2'b01;
  localparam logic [1:0] c_sela_alu = 2'b10;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [NB_ADDR-1:0]   r_pc;
  logic [NB_COUNT-1:0]  r_count;
  logic                 r_illegal;

  logic [NB_OPCODE-1:0] w_opcode;
  logic                 w_run;
  logic                 w_is_hlt;
  logic                 w_is_defined;

  logic [1:0]           w_sel_a;
  logic                 w_sel_b;
  logic                 w_wr_acc;
  logic                 w_alu_op;
  logic                 w_wr_ram;
  logic                 w_rd_ram;

  assign w_opcode     = i_instruction[NB_INSTR-1 -: NB_OPCODE];
  assign w_run        = (r_state == c_st_run);
  assign w_is_hlt     = (w_opcode == c_op_hlt);
  // Defined opcodes occupy the contiguous range HLT..SUBI.
  assign w_is_defined = (w_opcode <= c_op_subi);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. HALT is terminal until reset; i_start only matters in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (i_start) begin
          w_state_next = c_st_run;
        end
      end
      c_st_run: begin
        if (w_is_hlt) begin
          w_state_next = c_st_halt;
        end
      end
      c_st_halt: begin
        w_state_next = c_st_halt;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Purely combinational from state and opcode, so an
  // asynchronous reset drops every strobe immediately with no partial write.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_a  = c_sela_mem;
    w_sel_b  = 1'b0;
    w_wr_acc = 1'b0;
    w_alu_op = 1'b0;
    w_wr_ram = 1'b0;
    w_rd_ram = 1'b0;
    if (w_run) begin
      case (w_opcode)
        c_op_sto: begin
          w_wr_ram = 1'b1;
        end
        c_op_ld: begin
          w_wr_acc = 1'b1;
          w_rd_ram = 1'b1;
        end
        c_op_ldi: begin
          w_sel_a  = c_sela_imm;
          w_wr_acc = 1'b1;
        end
        c_op_add: begin
          w_sel_a  = c_sela_alu;
          w_wr_acc = 1'b1;
          w_rd_ram = 1'b1;
        end
        c_op_addi: begin
          w_sel_a  = c_sela_alu;
          w_sel_b  = 1'b1;
          w_wr_acc = 1'b1;
        end
        c_op_sub: begin
          w_sel_a  = c_sela_alu;
          w_alu_op = 1'b1;
          w_wr_acc = 1'b1;
          w_rd_ram = 1'b1;
        end
        c_op_subi: begin
          w_sel_a  = c_sela_alu;
          w_sel_b  = 1'b1;
          w_alu_op = 1'b1;
          w_wr_acc = 1'b1;
        end
        // HLT and undefined opcodes issue no strobes.
        default: begin
          w_sel_a = c_sela_mem;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Program counter, executed-instruction counter and sticky illegal flag.
  // PC wraps naturally at 2^NB_ADDR; the counter saturates at all-ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc      <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else if (w_run) begin
      if (!w_is_hlt) begin
        r_pc <= r_pc + 1'b1;
      end
      if (r_count != {NB_COUNT{1'b1}}) begin
        r_count <= r_count + 1'b1;
      end
      if (!w_is_defined) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign o_pc      = r_pc;
  assign o_operand = i_instruction[NB_ADDR-1:0];
  assign o_SelA    = w_sel_a;
  assign o_SelB    = w_sel_b;
  assign o_WrAcc   = w_wr_acc;
  assign o_op      = w_alu_op;
  assign o_WrRam   = w_wr_ram;
  assign o_RdRam   = w_rd_ram;
  assign o_halt    = (r_state == c_st_halt);
  assign o_illegal = r_illegal;
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_control_unit
// Description : Self-checking bench for bip_control_unit. A behavioural
//               model (run/halt flags, pc, count, illegal) is compared with
//               the main instance every falling edge; directed literal
//               checks pin the model. A second instance with NB_ADDR=3,
//               NB_COUNT=3 covers PC wrap and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_control_unit;

  logic        clk;
  logic        rst;
  logic        start_a;
  logic        start_b;

  // Main instance (default parameters)
  logic [15:0] instr_a;
  logic [10:0] pc_a, operand_a;
  logic [1:0]  sela_a;
  logic        selb_a, wracc_a, op_a, wrram_a, rdram_a, halt_a, illegal_a;
  logic [15:0] count_a;

  // Small instance (NB_ADDR=3, NB_COUNT=3)
  logic [15:0] instr_b;
  logic [2:0]  pc_b, operand_b;
  logic [1:0]  sela_b;
  logic        selb_b, wracc_b, op_b, wrram_b, rdram_b, halt_b, illegal_b;
  logic [2:0]  count_b;

  logic [15:0] prog [0:2047];
  logic [6:0]  tab  [0:7];

  int total;
  int bad;

  assign instr_a = prog[pc_a];
  // Every word is ADDI with operand equal to its own address.
  assign instr_b = {5'b00101, 8'd0, pc_b};

  bip_control_unit dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_instruction(instr_a),
    .o_pc(pc_a), .o_operand(operand_a), .o_SelA(sela_a), .o_SelB(selb_a),
    .o_WrAcc(wracc_a), .o_op(op_a), .o_WrRam(wrram_a), .o_RdRam(rdram_a),
    .o_halt(halt_a), .o_illegal(illegal_a), .o_count(count_a)
  );

  bip_control_unit #(.NB_INSTR(16), .NB_OPCODE(5), .NB_ADDR(3), .NB_COUNT(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_instruction(instr_b),
    .o_pc(pc_b), .o_operand(operand_b), .o_SelA(sela_b), .o_SelB(selb_b),
    .o_WrAcc(wracc_b), .o_op(op_b), .o_WrRam(wrram_b), .o_RdRam(rdram_b),
    .o_halt(halt_b), .o_illegal(illegal_b), .o_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the main instance
  // ---------------------------------------------------------------------------
  logic        m_run, m_halt, m_ill;
  logic [10:0] m_pc;
  logic [15:0] m_count;
  logic [15:0] m_ins;
  logic [6:0]  m_ctl;

  assign m_ins = prog[m_pc];
  // Controls {SelA,SelB,op,WrAcc,RdRam,WrRam}: table row while running a
  // defined opcode, otherwise all zero.
  assign m_ctl = (m_run && m_ins[15:14] == 2'b00 && m_ins[13] == 1'b0) ? tab[m_ins[13:11]] :
                 (m_run && m_ins[15:11] < 5'd8) ? tab[m_ins[13:11]] : 7'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run   <= 1'b0;
      m_halt  <= 1'b0;
      m_ill   <= 1'b0;
      m_pc    <= 11'd0;
      m_count <= 16'd0;
    end else if (m_run) begin
      m_count <= (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
      if (m_ins[15:11] > 5'd7) m_ill <= 1'b1;
      if (m_ins[15:11] == 5'd0) begin
        m_run  <= 1'b0;
        m_halt <= 1'b1;
      end else begin
        m_pc <= m_pc + 11'd1;
      end
    end else if (!m_halt && start_a) begin
      m_run <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model_pc",      {21'd0, pc_a}, {21'd0, m_pc});
    check("model_ctl",     {25'd0, sela_a, selb_a, op_a, wracc_a, rdram_a, wrram_a}, {25'd0, m_ctl});
    check("model_operand", {21'd0, operand_a}, {21'd0, m_ins[10:0]});
    check("model_halt",    {31'd0, halt_a}, {31'd0, m_halt});
    check("model_illegal", {31'd0, illegal_a}, {31'd0, m_ill});
    check("model_count",   {16'd0, count_a}, {16'd0, m_count});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
  endtask

  function automatic logic [31:0] ctl_a();
    return {25'd0, sela_a, selb_a, op_a, wracc_a, rdram_a, wrram_a};
  endfunction

  // Expected values for the LDI/ADD/SUBI/HLT program, {SelA,SelB,op,WrAcc,RdRam,WrRam}
  logic [6:0]  exp1_ctl   [0:4];
  logic [10:0] exp1_pc    [0:4];
  logic        exp1_halt  [0:4];
  logic [15:0] exp1_count [0:4];

  initial begin
    total = 0;
    bad   = 0;
    rst     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tab[0] = 7'b00_0_0_0_0_0; // HLT
    tab[1] = 7'b00_0_0_0_0_1; // STO
    tab[2] = 7'b00_0_0_1_1_0; // LD
    tab[3] = 7'b01_0_0_1_0_0; // LDI
    tab[4] = 7'b10_0_0_1_1_0; // ADD
    tab[5] = 7'b10_1_0_1_0_0; // ADDI
    tab[6] = 7'b10_0_1_1_1_0; // SUB
    tab[7] = 7'b10_1_1_1_0_0; // SUBI
    exp1_ctl[0] = 7'b0100100; exp1_ctl[1] = 7'b1000110; exp1_ctl[2] = 7'b1011100;
    exp1_ctl[3] = 7'b0000000; exp1_ctl[4] = 7'b0000000;
    exp1_pc[0] = 11'd0; exp1_pc[1] = 11'd1; exp1_pc[2] = 11'd2; exp1_pc[3] = 11'd3; exp1_pc[4] = 11'd3;
    exp1_halt[0] = 1'b0; exp1_halt[1] = 1'b0; exp1_halt[2] = 1'b0; exp1_halt[3] = 1'b0; exp1_halt[4] = 1'b1;
    exp1_count[0] = 16'd0; exp1_count[1] = 16'd1; exp1_count[2] = 16'd2;
    exp1_count[3] = 16'd3; exp1_count[4] = 16'd4;

    clear_prog();
    prog[0] = 16'h1801; // LDI 1
    prog[1] = 16'h2003; // ADD 3
    prog[2] = 16'h3805; // SUBI 5
    prog[3] = 16'h0000; // HLT

    // Reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    check("rst_pc",      {21'd0, pc_a}, 32'd0);
    check("rst_ctl",     ctl_a(), 32'd0);
    check("rst_halt",    {31'd0, halt_a}, 32'd0);
    check("rst_count",   {16'd0, count_a}, 32'd0);
    check("rst_illegal", {31'd0, illegal_a}, 32'd0);
    check("rst_operand", {21'd0, operand_a}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;

    // Idle: no progress without start
    @(negedge clk);
    @(negedge clk);
    check("idle_pc", {21'd0, pc_a}, 32'd0);

    // LDI 1 / ADD 3 / SUBI 5 / HLT
    pulse_start_a();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("p1_ctl",   ctl_a(), {25'd0, exp1_ctl[k]});
      check("p1_pc",    {21'd0, pc_a}, {21'd0, exp1_pc[k]});
      check("p1_halt",  {31'd0, halt_a}, {31'd0, exp1_halt[k]});
      check("p1_count", {16'd0, count_a}, {16'd0, exp1_count[k]});
    end
    // start is ignored in HALT
    pulse_start_a();
    @(negedge clk);
    @(negedge clk);
    check("halt_hold_pc",    {21'd0, pc_a}, 32'd3);
    check("halt_hold_count", {16'd0, count_a}, 32'd4);
    check("halt_hold_halt",  {31'd0, halt_a}, 32'd1);

    // STO 7 then HLT: exactly one write strobe
    apply_reset();
    clear_prog();
    prog[0] = 16'h0807;
    pulse_start_a();
    @(negedge clk);
    check("sto_wrram",   {31'd0, wrram_a}, 32'd1);
    check("sto_operand", {21'd0, operand_a}, 32'd7);
    check("sto_wracc",   {31'd0, wracc_a}, 32'd0);
    begin
      int wr_cycles;
      wr_cycles = 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (wrram_a) wr_cycles++;
      end
      check("sto_once", wr_cycles, 32'd1);
    end

    // Undefined opcode 11111 at PC 0, then HLT
    apply_reset();
    clear_prog();
    prog[0] = 16'hF800;
    pulse_start_a();
    @(negedge clk);
    check("ill_ctl",     ctl_a(), 32'd0);
    check("ill_flag0",   {31'd0, illegal_a}, 32'd0);
    @(negedge clk);
    check("ill_pc",      {21'd0, pc_a}, 32'd1);
    check("ill_flag1",   {31'd0, illegal_a}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("ill_halt",    {31'd0, halt_a}, 32'd1);
    check("ill_sticky",  {31'd0, illegal_a}, 32'd1);

    // Reset mid-RUN at PC 5 (all ADDI 1)
    apply_reset();
    clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 16'h2801;
    pulse_start_a();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pc_a == 11'd5) break;
    end
    check("wait_pc5",   {21'd0, pc_a}, 32'd5);
    check("pc5_wracc",  {31'd0, wracc_a}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_ctl", ctl_a(), 32'd0);
    check("midrst_pc",  {21'd0, pc_a}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_pc",  {21'd0, pc_a}, 32'd0);
      check("post_rst_ctl", ctl_a(), 32'd0);
    end
    pulse_start_a();
    @(negedge clk);
    @(negedge clk);
    check("restart_pc", {21'd0, pc_a}, 32'd1);

    // Small instance: PC wrap at 8, count saturates at 7
    apply_reset();
    @(negedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b_pc",      {29'd0, pc_b}, k % 8);
      check("b_operand", {29'd0, operand_b}, k % 8);
      check("b_count",   {29'd0, count_b}, (k < 7) ? k : 7);
      check("b_ctl",     {25'd0, sela_b, selb_b, op_b, wracc_b, rdram_b, wrram_b}, 32'b1010100);
      check("b_halt",    {31'd0, halt_b}, 32'd0);
    end
    check("b_illegal", {31'd0, illegal_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
